// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with optional two-entry skid buffer
// A bubble (out_valid=0) always presents all-zero data and control.
module pipe_skid_reg #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 32,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam bit HAS_SKID = (SKID != 0);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic w_out_valid;
  logic w_in_ready;
  logic w_accept;
  logic w_drain;

  assign w_out_valid = (r_state != S_EMPTY);

  // With a skid entry, in_ready depends on state only, breaking the ready chain.
  assign w_in_ready = HAS_SKID ? (r_state != S_TWO) : (~w_out_valid | out_ready);

  assign w_accept = in_valid & w_in_ready;
  assign w_drain  = w_out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (!nreset || flush) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state     <= S_ONE;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_accept) begin
            if (HAS_SKID) begin
              r_state     <= S_TWO;
              r_skid_data <= in_data;
              r_skid_ctrl <= in_ctrl;
            end
          end else if (w_drain) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_drain) begin
            r_state     <= S_ONE;
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_main_data : '0;
  assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed and random bench for pipe_skid_reg, SKID=1 and SKID=0
module tb_pipe_skid_reg;

  logic clock = 1'b0;
  logic nreset = 1'b1;
  logic flush = 1'b0;

  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
  logic [47:0] s_in_data = '0, s_out_data;
  logic [31:0] s_in_ctrl = '0, s_out_ctrl;
  logic [1:0]  s_occ;

  logic        n_in_valid = 1'b0, n_in_ready, n_out_valid, n_out_ready = 1'b1;
  logic [47:0] n_in_data = '0, n_out_data;
  logic [31:0] n_in_ctrl = '0, n_out_ctrl;
  logic [1:0]  n_occ;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  pipe_skid_reg #(.DATA_W(48), .CTRL_W(32), .SKID(1)) u_skid (
    .clock(clock), .nreset(nreset), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .occupancy(s_occ)
  );

  pipe_skid_reg #(.DATA_W(48), .CTRL_W(32), .SKID(0)) u_noskid (
    .clock(clock), .nreset(nreset), .flush(flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_ctrl(n_in_ctrl),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
    .occupancy(n_occ)
  );

  function automatic logic [31:0] ctrl_of(input logic [47:0] d);
    return {d[15:0], ~d[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic s_push(input logic [47:0] d);
    s_in_valid = 1'b1;
    s_in_data  = d;
    s_in_ctrl  = ctrl_of(d);
  endtask

  task automatic n_push(input logic [47:0] d);
    n_in_valid = 1'b1;
    n_in_data  = d;
    n_in_ctrl  = ctrl_of(d);
  endtask

  logic [79:0] s_q[$];
  logic [79:0] n_q[$];

  initial begin
    // Reset held two cycles with in_valid high
    nreset = 1'b0;
    s_push(48'h99);
    n_push(48'h99);
    tick(); tick();
    chk("rst_valid", s_out_valid, 0);
    chk("rst_ctrl",  s_out_ctrl, 0);
    chk("rst_data",  s_out_data, 0);
    chk("rst_occ",   s_occ, 0);
    chk("rst_n_occ", n_occ, 0);
    nreset = 1'b1;
    s_in_valid = 1'b0;
    n_in_valid = 1'b0;
    #1;
    chk("rst_in_ready",   s_in_ready, 1);
    chk("rst_n_in_ready", n_in_ready, 1);

    // Streaming A, B, C with out_ready=1
    s_out_ready = 1'b1;
    s_push(48'h11);
    tick();
    chk("str_a_data", s_out_data, 48'h11);
    chk("str_a_ctrl", s_out_ctrl, 32'h0011ffee);
    chk("str_a_occ",  s_occ, 1);
    s_push(48'h22);
    tick();
    chk("str_b_data", s_out_data, 48'h22);
    chk("str_b_occ",  s_occ, 1);
    s_push(48'h33);
    tick();
    chk("str_c_data", s_out_data, 48'h33);
    chk("str_c_occ",  s_occ, 1);
    s_in_valid = 1'b0;
    tick();
    chk("str_end_occ",   s_occ, 0);
    chk("str_end_valid", s_out_valid, 0);

    // Backpressure fills the skid entry
    s_out_ready = 1'b0;
    s_push(48'h11);
    tick();
    s_push(48'h22);
    tick();
    s_in_valid = 1'b0;
    chk("bp_occ2",     s_occ, 2);
    chk("bp_in_ready", s_in_ready, 0);
    chk("bp_data_a",   s_out_data, 48'h11);
    s_in_data = 48'hdead;
    tick();
    chk("bp_hold_a",    s_out_data, 48'h11);
    chk("bp_hold_ctrl", s_out_ctrl, 32'h0011ffee);
    s_out_ready = 1'b1;
    tick();
    chk("bp_data_b", s_out_data, 48'h22);
    chk("bp_occ1",   s_occ, 1);
    tick();
    chk("bp_occ0",  s_occ, 0);
    chk("bp_zero",  s_out_data, 0);

    // Flush while full, with C offered the same cycle
    s_out_ready = 1'b0;
    s_push(48'h11);
    tick();
    s_push(48'h22);
    tick();
    chk("fl_occ2", s_occ, 2);
    flush = 1'b1;
    s_push(48'h33);
    tick();
    flush = 1'b0;
    s_in_valid = 1'b0;
    chk("fl_occ0",  s_occ, 0);
    chk("fl_valid", s_out_valid, 0);
    chk("fl_ctrl",  s_out_ctrl, 0);
    s_out_ready = 1'b1;
    tick();
    chk("fl_no_c", s_out_valid, 0);

    // Flush from EMPTY discards the entry accepted that cycle
    flush = 1'b1;
    s_push(48'h44);
    tick();
    flush = 1'b0;
    s_in_valid = 1'b0;
    chk("fl_acc_occ", s_occ, 0);

    // Reset mid-operation drops held entries
    s_out_ready = 1'b0;
    s_push(48'h55);
    tick();
    s_in_valid = 1'b0;
    chk("mr_occ1", s_occ, 1);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("mr_occ0",  s_occ, 0);
    chk("mr_valid", s_out_valid, 0);
    s_out_ready = 1'b1;

    // SKID=0: combinational in_ready with same-cycle accept and drain
    n_out_ready = 1'b0;
    n_push(48'h11);
    tick();
    n_push(48'h22);
    #1;
    chk("ns_in_ready0", n_in_ready, 0);
    chk("ns_data_a",    n_out_data, 48'h11);
    tick();
    chk("ns_hold_a", n_out_data, 48'h11);
    chk("ns_occ1",   n_occ, 1);
    n_out_ready = 1'b1;
    #1;
    chk("ns_in_ready1", n_in_ready, 1);
    tick();
    n_in_valid = 1'b0;
    chk("ns_data_b", n_out_data, 48'h22);
    chk("ns_occ_b",  n_occ, 1);
    tick();
    chk("ns_occ0", n_occ, 0);

    // Random valid/ready against a queue scoreboard on both instances
    for (int cyc = 0; cyc < 10000; cyc++) begin
      s_in_valid  = ($urandom_range(0, 9) < 7);
      s_in_data   = {$urandom(), $urandom()};
      s_in_ctrl   = $urandom();
      s_out_ready = ($urandom_range(0, 9) < 6);
      n_in_valid  = ($urandom_range(0, 9) < 7);
      n_in_data   = {$urandom(), $urandom()};
      n_in_ctrl   = $urandom();
      n_out_ready = ($urandom_range(0, 9) < 6);
      #1;
      chk("rnd_s_occ", s_occ, s_q.size());
      chk("rnd_n_occ", n_occ, n_q.size());
      if (s_out_valid && s_out_ready)
        chk("rnd_s_out", {s_out_ctrl, s_out_data}, (s_q.size() != 0) ? s_q.pop_front() : '1);
      if (n_out_valid && n_out_ready)
        chk("rnd_n_out", {n_out_ctrl, n_out_data}, (n_q.size() != 0) ? n_q.pop_front() : '1);
      if (s_in_valid && s_in_ready) s_q.push_back({s_in_ctrl, s_in_data});
      if (n_in_valid && n_in_ready) n_q.push_back({n_in_ctrl, n_in_data});
      tick();
    end
    chk("rnd_s_max", (s_q.size() <= 2), 1);
    chk("rnd_n_max", (n_q.size() <= 1), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
